comma_aligner: RTL and testbench
================================

COMMA_ALIGNER -- requirements
Module: comma_aligner

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 3: number of in-phase commas, counting the first one, needed to declare sync.
REQ-002 SHALL have parameter LOSS_CNT, default 3: number of consecutive misphased commas in SYNC that forces HUNT.
REQ-003 SHALL have port clk, input, 1: the single receive clock; one serial bit per rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port serial_in, input, 1: received line bit; the first bit of each character is bit a.
REQ-006 SHALL have port data10_out, output, 10: aligned character, registered; [0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=i, [6]=f, [7]=g, [8]=h, [9]=j; feeds the decoder data10_in.
REQ-007 SHALL have port word_valid, output, 1: one-cycle strobe; data10_out holds a new character.
REQ-008 SHALL have port aligned, output, 1: high only in state SYNC.
REQ-009 SHALL have port comma_det, output, 1: one-cycle strobe; a capture was triggered by a comma.

Function
REQ-010 SHALL shift serial_in into a 10-bit window sr every cycle; the oldest bit is sr[0] (a) and the newest is sr[9] (j).
REQ-011 SHALL raise internal comma_hit when sr bits a,b,c,d,e,i,f equal 0,0,1,1,1,1,1 or 1,1,0,0,0,0,0.
REQ-012 SHALL keep a phase counter ph in 0..9: ph is set to 0 on every capture and otherwise increments by 1, wrapping from 9 to 0.
REQ-013 SHALL define a capture as: data10_out<=sr and word_valid<=1 on the same edge; in all other cycles word_valid<=0.
REQ-014 SHALL define a comma as in-phase when comma_hit is true while ph==9, and misphased when ph!=9.
REQ-015 SHALL have latency: bit j sampled at edge N, capture at edge N+1, word_valid high during cycle N+1..N+2.
REQ-016 SHALL use states HUNT, CHECK and SYNC.
REQ-017 SHALL behave in HUNT as follows: no ph-driven captures; comma_hit -> capture, comma_det=1, cnt<=1, go to CHECK.
REQ-018 SHALL behave in CHECK as follows: capture when ph==9.
- in-phase comma -> cnt+1; if cnt+1==LOCK_CNT, go to SYNC.
- misphased comma -> capture at the new phase, cnt<=1, stay in CHECK.
REQ-019 SHALL behave in SYNC as follows: capture when ph==9.
- in-phase comma clears miss.
- misphased comma -> no capture, miss+1; if miss+1==LOSS_CNT, go to HUNT with miss<=0.
REQ-020 SHALL, when comma_hit and ph==9 coincide, treat the event as an in-phase comma: a single capture with comma_det=1.
REQ-021 SHALL set comma_det only on comma-triggered or in-phase-comma captures.
REQ-022 SHALL saturate cnt and miss, and size each to hold its parameter value.

Reset
REQ-023 SHALL, while rst is high at a clock edge, load sr=0, ph=0, cnt=0, miss=0, state=HUNT, data10_out=0, word_valid=0, aligned=0 and comma_det=0.
REQ-024 SHALL, on reset during any state, abandon any partial character; the next lock requires a full HUNT sequence.

Configuration
REQ-025 SHALL support macro RX_REALIGN_EN.
- Defined: in SYNC, a misphased comma immediately causes a capture at the new phase, comma_det=1, cnt<=1, and a move to CHECK; the miss counter is not implemented.
- Undefined: REQ-019 misphased-comma behaviour applies.

Structure
REQ-026 SHALL place the state encodings (HUNT=0, CHECK=1, SYNC=2) and the two comma patterns in shared include file rx_pcs_defs.vh, for reuse by the decoder side.
REQ-027 SHALL instantiate sub-module comma_detect: a 7-bit input and a 1-bit comma_hit output, combinational.

Verification
REQ-028 SHALL cover reset: hold rst for 3 cycles with random serial_in -> all outputs 0, aligned=0, no word_valid.
REQ-029 SHALL cover lock: send 20 random bits, then K28.5 RD- (0011111010) three times back-to-back -> first capture data10_out=10'b0101111100, aligned=1 after the third comma, word_valid every 10 cycles.
REQ-030 SHALL cover bit slip: after lock, insert one extra bit, then send K28.5 x3 -> without the macro, aligned drops after the 3rd misphased comma, then relocks; with RX_REALIGN_EN, an immediate capture at the new phase.
REQ-031 SHALL cover data integrity: locked stream of D21.5 (1010101010) -> data10_out=10'h155 on every strobe, comma_det=0.
REQ-032 SHALL cover reset mid-operation: assert rst 4 bits into a SYNC character -> outputs cleared next cycle, state HUNT, and a relock needs LOCK_CNT commas.
REQ-033 SHALL cover polarity: alternate K28.5 RD- and RD+ (1100000101) -> both are detected; in-phase commas keep aligned=1.

Source files
------------

// File: rtl/comma_aligner_pkg.sv
// comma_aligner_pkg: state type, comma patterns and counter sizing shared by the
// comma aligner files.
`include "rx_pcs_defs.vh"

package comma_aligner_pkg;

  typedef enum logic [1:0] {
    HUNT  = `RX_ST_HUNT,
    CHECK = `RX_ST_CHECK,
    SYNC  = `RX_ST_SYNC
  } state_t;

  localparam logic [6:0] COMMA_POS = `RX_COMMA_POS;
  localparam logic [6:0] COMMA_NEG = `RX_COMMA_NEG;
  localparam logic [3:0] PH_LAST   = 4'd9;

  // Bits needed to hold the value v itself, so a count can saturate at v.
  function automatic int cnt_width(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

endpackage

// File: rtl/comma_aligner_comma_detect.sv
// comma_detect: flags either polarity of the 7-bit comma prefix in the
// oldest bits {f,i,e,d,c,b,a} of the receive window.
module comma_detect
  import comma_aligner_pkg::*;
(
  input  logic [6:0] i_window,
  output logic       comma_hit
);

  assign comma_hit = (i_window == COMMA_POS) || (i_window == COMMA_NEG);

endmodule

// File: rtl/rx_pcs_defs.vh
// Shared 8b/10b receive-PCS definitions: aligner state codes and the two comma
// patterns, also used on the decoder side.
`ifndef RX_PCS_DEFS_VH
`define RX_PCS_DEFS_VH

`define RX_ST_HUNT  2'd0
`define RX_ST_CHECK 2'd1
`define RX_ST_SYNC  2'd2

// Window bits {f,i,e,d,c,b,a}; a is bit 0 and is the first bit on the line.
`define RX_COMMA_POS 7'b1111100
`define RX_COMMA_NEG 7'b0000011

`endif

// File: rtl/comma_aligner.sv
// comma_aligner: serial 8b/10b comma alignment with HUNT/CHECK/SYNC lock FSM.
// Build option RX_REALIGN_EN: a misphased comma in SYNC realigns at once (no miss counter).
module comma_aligner
  import comma_aligner_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [9:0] data10_out,
  output logic       word_valid,
  output logic       aligned,
  output logic       comma_det
);

  // state | meaning
  // HUNT  | no phase; the first comma seen picks the character boundary
  // CHECK | phase picked; counting in-phase commas toward LOCK_CNT
  // SYNC  | locked; capture every 10 bits, misphased commas counted toward LOSS_CNT

  localparam int               CNT_W    = cnt_width(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam state_t           LOCK_TGT = (LOCK_CNT <= 1) ? SYNC : CHECK;

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_sr, r_data;
  logic [3:0]       r_ph;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_valid, r_det;
  logic             w_comma_hit, w_ph_last, w_in_phase, w_misphased;
  logic             w_cnt_lock, w_capture, w_det;

`ifndef RX_REALIGN_EN
  localparam int                MISS_W   = cnt_width(LOSS_CNT);
  localparam logic [MISS_W-1:0] MISS_SAT = MISS_W'(LOSS_CNT);
  localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);
  logic [MISS_W-1:0] r_miss, w_miss_nxt, w_miss_inc;
  logic              w_miss_loss;
`endif

  comma_detect u_comma_detect (
    .i_window  (r_sr[6:0]),
    .comma_hit (w_comma_hit)
  );

  assign w_ph_last   = (r_ph == PH_LAST);
  assign w_in_phase  = w_comma_hit && w_ph_last;
  assign w_misphased = w_comma_hit && !w_ph_last;
  assign w_cnt_inc   = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CNT_ONE;
  assign w_cnt_lock  = (int'(r_cnt) + 1 >= LOCK_CNT);
`ifndef RX_REALIGN_EN
  assign w_miss_inc  = (r_miss == MISS_SAT) ? r_miss : r_miss + MISS_ONE;
  assign w_miss_loss = (int'(r_miss) + 1 >= LOSS_CNT);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      HUNT:  if (w_comma_hit) w_state_nxt = LOCK_TGT;
      CHECK: if (w_in_phase && w_cnt_lock) w_state_nxt = SYNC;
      SYNC: begin
`ifdef RX_REALIGN_EN
        if (w_misphased) w_state_nxt = LOCK_TGT;
`else
        if (w_misphased && w_miss_loss) w_state_nxt = HUNT;
`endif
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // A comma coinciding with ph==9 is one in-phase event: a single capture.
  always_comb begin
    w_capture = 1'b0;
    w_det     = 1'b0;
    w_cnt_nxt = r_cnt;
`ifndef RX_REALIGN_EN
    w_miss_nxt = r_miss;
`endif
    unique case (r_state)
      HUNT: begin
        if (w_comma_hit) begin
          w_capture = 1'b1;
          w_det     = 1'b1;
          w_cnt_nxt = CNT_ONE;
        end
      end
      CHECK: begin
        if (w_ph_last) begin
          w_capture = 1'b1;
          if (w_comma_hit) begin
            w_det     = 1'b1;
            w_cnt_nxt = w_cnt_inc;
          end
        end else if (w_comma_hit) begin
          w_capture = 1'b1;
          w_det     = 1'b1;
          w_cnt_nxt = CNT_ONE;
        end
      end
      SYNC: begin
        if (w_ph_last) begin
          w_capture = 1'b1;
          if (w_comma_hit) begin
            w_det = 1'b1;
`ifndef RX_REALIGN_EN
            w_miss_nxt = '0;
`endif
          end
        end else if (w_comma_hit) begin
`ifdef RX_REALIGN_EN
          w_capture = 1'b1;
          w_det     = 1'b1;
          w_cnt_nxt = CNT_ONE;
`else
          w_miss_nxt = w_miss_loss ? '0 : w_miss_inc;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr    <= '0;
      r_ph    <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_det   <= 1'b0;
    end else begin
      r_sr    <= {serial_in, r_sr[9:1]};
      r_ph    <= (w_capture || w_ph_last) ? 4'd0 : r_ph + 4'd1;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_capture;
      r_det   <= w_det;
      if (w_capture) r_data <= r_sr;
    end
  end

`ifndef RX_REALIGN_EN
  always_ff @(posedge clk) begin
    if (rst) r_miss <= '0;
    else     r_miss <= w_miss_nxt;
  end
`endif

  assign data10_out = r_data;
  assign word_valid = r_valid;
  assign comma_det  = r_det;
  assign aligned    = (r_state == SYNC);

endmodule

// File: tb/tb_comma_aligner.sv
// tb_comma_aligner: directed serial stimulus for comma_aligner; every expected
// capture is queued as its character is sent and checked when word_valid strobes.
module tb_comma_aligner;

  // Characters in line order: MSB is bit a, sent first.
  localparam logic [9:0] K_NEG = 10'b0011111010;
  localparam logic [9:0] K_POS = 10'b1100000101;
  localparam logic [9:0] D21_5 = 10'b1010101010;

  typedef struct packed {
    logic [9:0] data;
    logic       det;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic [9:0] data10_out;
  logic       word_valid;
  logic       aligned;
  logic       comma_det;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  bit   mon_en   = 1'b0;
  bit   chk_gap  = 1'b0;
  bit   have_last = 1'b0;
  int   cyc      = 0;
  int   last_cyc = 0;
  logic rb, rprev;
  int   rrun;

  comma_aligner #(.LOCK_CNT(3), .LOSS_CNT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .data10_out (data10_out),
    .word_valid (word_valid),
    .aligned    (aligned),
    .comma_det  (comma_det)
  );

  always #5 clk = ~clk;

  // Line order -> data10_out order ([0]=a ... [9]=j).
  function automatic logic [9:0] rev10(input logic [9:0] tx);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = tx[9-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [9:0] tx);
    for (int i = 9; i >= 0; i--) send_bit(tx[i]);
  endtask

  task automatic push(input logic [9:0] window_tx, input logic det);
    exp_t e;
    e.data = rev10(window_tx);
    e.det  = det;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (word_valid === 1'b1) begin
        chk("strobe_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          chk("data10_out", 32'(data10_out), 32'(mon_e.data));
          chk("comma_det", 32'(comma_det), 32'(mon_e.det));
        end
        if (chk_gap && have_last) chk("strobe_gap", 32'(cyc - last_cyc), 32'd10);
        last_cyc  = cyc;
        have_last = 1'b1;
      end else begin
        chk("comma_det_idle", 32'(comma_det), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    serial_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      mon_en = 1'b1;
    end
    chk("rst_data", 32'(data10_out), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_aligned", 32'(aligned), 32'd0);
    chk("rst_det", 32'(comma_det), 32'd0);
    rst = 1'b0;

    // Random lead-in; runs kept short and tail forced to 1,0 so no comma forms early.
    rprev = 1'b0;
    rrun  = 0;
    for (int i = 0; i < 20; i++) begin
      rb = 1'($urandom_range(0, 1));
      if (i > 0 && rb == rprev && rrun == 3) rb = ~rb;
      if (i == 18) rb = 1'b1;
      if (i == 19) rb = 1'b0;
      rrun  = (i > 0 && rb == rprev) ? rrun + 1 : 1;
      rprev = rb;
      send_bit(rb);
    end
    chk("hunt_aligned", 32'(aligned), 32'd0);

    push(K_NEG, 1'b1); send_char(K_NEG);
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk_gap = 1'b1;
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk("lock_pre_aligned", 32'(aligned), 32'd0);
    for (int i = 0; i < 6; i++) begin
      push(D21_5, 1'b0); send_char(D21_5);
    end
    chk("lock_aligned", 32'(aligned), 32'd1);

    // Bit slip: one extra '1' shifts the stream against the locked phase.
    chk_gap = 1'b0;
    push({1'b1, K_NEG[9:1]}, 1'b0);
    send_bit(1'b1);
`ifdef RX_REALIGN_EN
    push(K_NEG, 1'b1); send_char(K_NEG);
    push(K_NEG, 1'b1); send_char(K_NEG);
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk("slip_k3_aligned", 32'(aligned), 32'd0);
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk("slip_k4_aligned", 32'(aligned), 32'd1);
`else
    send_char(K_NEG);
    push({K_NEG[0], K_NEG[9:1]}, 1'b0); send_char(K_NEG);
    push({K_NEG[0], K_NEG[9:1]}, 1'b0); send_char(K_NEG);
    chk("slip_k3_aligned", 32'(aligned), 32'd1);
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk("slip_k4_aligned", 32'(aligned), 32'd0);
`endif
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk_gap = 1'b1;
    push(K_NEG, 1'b1); send_char(K_NEG);
    push(D21_5, 1'b0); send_char(D21_5);
    chk("relock_slip_aligned", 32'(aligned), 32'd1);
    for (int i = 0; i < 3; i++) begin
      push(D21_5, 1'b0); send_char(D21_5);
    end

    // Reset four bits into a character.
    chk_gap = 1'b0;
    for (int i = 9; i >= 6; i--) send_bit(D21_5[i]);
    rst = 1'b1;
    send_bit(D21_5[5]);
    chk("midrst_data", 32'(data10_out), 32'd0);
    chk("midrst_valid", 32'(word_valid), 32'd0);
    chk("midrst_aligned", 32'(aligned), 32'd0);
    chk("midrst_det", 32'(comma_det), 32'd0);
    rst = 1'b0;
    have_last = 1'b0;
    push(K_NEG, 1'b1); send_char(K_NEG);
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk_gap = 1'b1;
    push(K_NEG, 1'b1); send_char(K_NEG);
    chk("relock_pre_aligned", 32'(aligned), 32'd0);
    push(D21_5, 1'b0); send_char(D21_5);
    chk("relock_aligned", 32'(aligned), 32'd1);

    // Alternating running disparity commas, all in phase.
    for (int i = 0; i < 2; i++) begin
      push(K_POS, 1'b1); send_char(K_POS);
      chk("pol_aligned", 32'(aligned), 32'd1);
      push(K_NEG, 1'b1); send_char(K_NEG);
    end
    push(D21_5, 1'b0); send_char(D21_5);
    send_bit(1'b0);
    send_bit(1'b1);
    #5;
    chk("pol_end_aligned", 32'(aligned), 32'd1);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
